// File: rtl/csa_multiword_sequencer_if.sv
// Operand and result handshakes for the multi-word carry-skip adder sequencer.
// The master side supplies operands and consumes results. The slave side is the sequencer.
interface csa_multiword_sequencer_if #(
    parameter int WIDE_SIZE = 64
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDE_SIZE-1:0] A;
    logic [WIDE_SIZE-1:0] B;
    logic                 Cin;
    logic                 out_valid;
    logic                 out_ready;
    logic [WIDE_SIZE-1:0] Sout;
    logic                 Cout;
    logic                 Ovf;

    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sout, Cout, Ovf
    );

    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sout, Cout, Ovf
    );
endinterface

// File: rtl/csa_multiword_sequencer.sv
// Wide adder that processes one SLICE_SIZE slice per cycle, least-significant slice first.
// Each slice goes through a carry-skip adder, and the carry between slices is held in a register.
module csa_multiword_sequencer #(
    parameter int WIDE_SIZE  = 64,
    parameter int SLICE_SIZE = 16,
    parameter int BLOCK_SIZE = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    csa_multiword_sequencer_if.slave bus
);
    localparam int NUM_SLICES = WIDE_SIZE / SLICE_SIZE;
    localparam int NUM_BLOCKS = SLICE_SIZE / BLOCK_SIZE;
    localparam int IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SLICES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [WIDE_SIZE-1:0]  a_q, a_d;
    logic [WIDE_SIZE-1:0]  b_q, b_d;
    logic                  carry_q, carry_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [WIDE_SIZE-1:0]  sout_q, sout_d;
    logic                  cout_q, cout_d;
    logic                  ovf_q, ovf_d;
    logic                  in_ready_q, in_ready_d;
    logic                  out_valid_q, out_valid_d;

    logic [SLICE_SIZE-1:0] slice_a, slice_b, slice_sum;
    logic                  slice_cout;
    logic                  skip_c, group_c, prop, prop_all;

    assign slice_a = a_q[idx_q*SLICE_SIZE +: SLICE_SIZE];
    assign slice_b = b_q[idx_q*SLICE_SIZE +: SLICE_SIZE];

    // Each group ripples internally. A group that fully propagates hands its carry-in straight on.
    always_comb begin
        slice_sum = '0;
        skip_c    = carry_q;
        group_c   = 1'b0;
        prop      = 1'b0;
        prop_all  = 1'b0;
        for (int g = 0; g < NUM_BLOCKS; g++) begin
            group_c  = skip_c;
            prop_all = 1'b1;
            for (int i = 0; i < BLOCK_SIZE; i++) begin
                prop                         = slice_a[g*BLOCK_SIZE+i] ^ slice_b[g*BLOCK_SIZE+i];
                slice_sum[g*BLOCK_SIZE+i]    = prop ^ group_c;
                group_c                      = (slice_a[g*BLOCK_SIZE+i] & slice_b[g*BLOCK_SIZE+i]) |
                                               (prop & group_c);
                prop_all                     = prop_all & prop;
            end
            skip_c = prop_all ? skip_c : group_c;
        end
        slice_cout = skip_c;
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        carry_d     = carry_q;
        idx_d       = idx_q;
        sout_d      = sout_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d        = bus.A;
                    b_d        = bus.B;
                    carry_d    = bus.Cin;
                    idx_d      = '0;
                    state_d    = RUN;
                    in_ready_d = 1'b0;
                end
            end
            RUN: begin
                sout_d[idx_q*SLICE_SIZE +: SLICE_SIZE] = slice_sum;
                carry_d = slice_cout;
                if (idx_q == LAST_IDX) begin
                    // On the last slice, the top bit of slice_sum is the sign bit of the full sum.
                    state_d     = DONE;
                    cout_d      = slice_cout;
                    ovf_d       = slice_cout ^ (a_q[WIDE_SIZE-1] ^ b_q[WIDE_SIZE-1] ^
                                                slice_sum[SLICE_SIZE-1]);
                    out_valid_d = 1'b1;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            sout_q      <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            sout_q      <= sout_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Sout      = sout_q;
    assign bus.Cout      = cout_q;
    assign bus.Ovf       = ovf_q;
endmodule
